// File: rtl/cms_pix_28_fw_cfg_shifter_if.sv
// SW op-code/readback bus and DUT configuration-chain pins of the config shifter.
interface cms_pix_28_fw_cfg_shifter_if;
    logic        fw_dev_id_enable;
    logic        fw_op_code_w_reset;
    logic        fw_op_code_w_cfg_array_0;
    logic        fw_op_code_r_cfg_array_0;
    logic        fw_op_code_w_execute;
    logic [23:0] sw_write24_0;
    logic [31:0] fw_read_data32;
    logic [31:0] fw_read_status32;
    logic        fw_config_clk;
    logic        fw_config_in;
    logic        fw_config_load;
    logic        fw_config_out;

    modport master (
        output fw_dev_id_enable, fw_op_code_w_reset, fw_op_code_w_cfg_array_0,
               fw_op_code_r_cfg_array_0, fw_op_code_w_execute, sw_write24_0, fw_config_out,
        input  fw_read_data32, fw_read_status32, fw_config_clk, fw_config_in, fw_config_load
    );

    modport slave (
        input  fw_dev_id_enable, fw_op_code_w_reset, fw_op_code_w_cfg_array_0,
               fw_op_code_r_cfg_array_0, fw_op_code_w_execute, sw_write24_0, fw_config_out,
        output fw_read_data32, fw_read_status32, fw_config_clk, fw_config_in, fw_config_load
    );
endinterface

// File: rtl/cms_pix_28_fw_cfg_shifter.sv
// Buffers a SW-pushed configuration image, shifts it into the DUT chain at a
// programmable rate, and captures the chain output for readback.
module cms_pix_28_fw_cfg_shifter #(
    parameter int CHAIN_LEN = 768,
    parameter int DATA_W    = 16
) (
    input  logic                      fw_clk,
    input  logic                      fw_rst,
    cms_pix_28_fw_cfg_shifter_if.slave bus
);
    localparam int NWORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PW     = $clog2(NWORDS + 1);
    localparam int BIW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [WW-1:0]  LAST_WI = WW'(NWORDS - 1);
    localparam logic [BIW-1:0] LAST_BI = BIW'((CHAIN_LEN - 1) % DATA_W);
    localparam logic [BIW-1:0] TOP_BI  = BIW'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_LOAD, S_DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_wbuf [NWORDS];
    logic [DATA_W-1:0] r_rbuf [NWORDS];
    logic [PW-1:0]     r_wr_ptr;
    logic [WW-1:0]     r_rd_ptr;
    logic [WW-1:0]     r_wi;
    logic [BIW-1:0]    r_bi;
    logic [8:0]        r_cnt;
    logic [7:0]        r_h;
    logic              r_load_en, r_busy, r_done, r_ovf, r_busy_err;
    logic              r_cfg_clk, r_cfg_in, r_cfg_load;
    logic [31:0]       r_rdata;

    logic              w_rst, w_exe, w_push, w_read;
    logic [7:0]        w_h;
    logic              w_ph_end, w_ld_end;
    logic [WW-1:0]     w_nwi;
    logic [BIW-1:0]    w_nbi;

    // Reset beats everything; otherwise execute > push > read.
    assign w_rst  = fw_rst | (bus.fw_dev_id_enable & bus.fw_op_code_w_reset);
    assign w_exe  = bus.fw_dev_id_enable & bus.fw_op_code_w_execute;
    assign w_push = bus.fw_dev_id_enable & bus.fw_op_code_w_cfg_array_0 & ~w_exe;
    assign w_read = bus.fw_dev_id_enable & bus.fw_op_code_r_cfg_array_0 & ~w_exe & ~w_push;

    assign w_h      = (r_h == 8'd0) ? 8'd1 : r_h;
    assign w_ph_end = (r_cnt == ({1'b0, w_h} - 9'd1));
    assign w_ld_end = (r_cnt == ({w_h, 1'b0} - 9'd1));
    assign w_nbi    = (r_bi == TOP_BI) ? '0 : r_bi + 1'b1;
    assign w_nwi    = (r_bi == TOP_BI) ? r_wi + 1'b1 : r_wi;

    assign bus.fw_config_clk    = r_cfg_clk;
    assign bus.fw_config_in     = r_cfg_in;
    assign bus.fw_config_load   = r_cfg_load;
    assign bus.fw_read_data32   = r_rdata;
    assign bus.fw_read_status32 = {16'(r_wr_ptr), r_h, 4'd0, r_busy_err, r_ovf, r_done, r_busy};

    always_ff @(posedge fw_clk) begin
        if (w_rst) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < NWORDS; i++) begin
                r_wbuf[i] <= '0;
                r_rbuf[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wi       <= '0;
            r_bi       <= '0;
            r_cnt      <= '0;
            r_h        <= '0;
            r_load_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy_err <= 1'b0;
            r_cfg_clk  <= 1'b0;
            r_cfg_in   <= 1'b0;
            r_cfg_load <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (r_busy && (w_exe || w_push || w_read)) begin
                r_busy_err <= 1'b1;
            end else if (w_push) begin
                // Tail bits past CHAIN_LEN are stored but never shifted.
                if (r_wr_ptr == PW'(NWORDS)) r_ovf <= 1'b1;
                else begin
                    r_wbuf[WW'(r_wr_ptr)] <= bus.sw_write24_0[DATA_W-1:0];
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                end
            end else if (w_read) begin
                r_rdata  <= 32'(r_rbuf[r_rd_ptr]);
                r_rd_ptr <= (r_rd_ptr == LAST_WI) ? '0 : r_rd_ptr + 1'b1;
            end

            case (r_state)
                S_IDLE: if (w_exe) begin
                    r_h       <= bus.sw_write24_0[15:8];
                    r_load_en <= bus.sw_write24_0[0];
                    r_rd_ptr  <= '0;
                    r_wi      <= '0;
                    r_bi      <= '0;
                    r_cnt     <= '0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b1;
                    r_cfg_in  <= r_wbuf[0][0];
                    r_state   <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    r_cnt <= r_cnt + 9'd1;
                    if (w_ph_end) begin
                        r_cnt              <= '0;
                        r_cfg_clk          <= 1'b1;
                        r_rbuf[r_wi][r_bi] <= bus.fw_config_out;
                        r_state            <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    r_cnt <= r_cnt + 9'd1;
                    if (w_ph_end) begin
                        r_cnt     <= '0;
                        r_cfg_clk <= 1'b0;
                        if (r_wi == LAST_WI && r_bi == LAST_BI) begin
                            r_cfg_in <= 1'b0;
                            if (r_load_en) begin
                                r_cfg_load <= 1'b1;
                                r_state    <= S_LOAD;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_wi     <= w_nwi;
                            r_bi     <= w_nbi;
                            r_cfg_in <= r_wbuf[w_nwi][w_nbi];
                            r_state  <= S_SHIFT_LO;
                        end
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 9'd1;
                    if (w_ld_end) begin
                        r_cfg_load <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cms_pix_28_fw_cfg_shifter.sv
// Bench for the config shifter: cycle-by-cycle comparison against an arithmetic
// model of the shift stream, plus directed literal expectations.
module tb_cms_pix_28_fw_cfg_shifter;
    localparam int L = 20, DW = 8, NW = 3;

    logic fw_clk = 1'b0;
    logic fw_rst = 1'b1;
    cms_pix_28_fw_cfg_shifter_if bus();

    cms_pix_28_fw_cfg_shifter #(.CHAIN_LEN(L), .DATA_W(DW)) dut (
        .fw_clk (fw_clk),
        .fw_rst (fw_rst),
        .bus    (bus)
    );

    always #5 fw_clk = ~fw_clk;

    int n_pass = 0, n_tot = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model chain on the DUT pins; MSB is the serial output.
    logic [L-1:0] chain = '0;
    assign bus.fw_config_out = chain[L-1];
    always @(posedge bus.fw_config_clk) chain <= {chain[L-2:0], bus.fw_config_in};

    // Capture of fw_config_in at each chain clock rise, plus rise spacing.
    logic [L-1:0] cap;
    int cap_n = 0, cyc = 0, last_rise = 0, bad_gap = 0, gap_exp = 4, n_busy = 0, n_load = 0;
    always @(posedge fw_clk) cyc++;
    always @(posedge bus.fw_config_clk) begin
        if (cap_n < L) cap[cap_n] = bus.fw_config_in;
        if (cap_n > 0 && (cyc - last_rise) != gap_exp) bad_gap++;
        last_rise = cyc;
        cap_n++;
    end
    always @(negedge fw_clk) begin
        if (bus.fw_config_load === 1'b1) n_load++;
        if (bus.fw_read_status32[0] === 1'b1) n_busy++;
    end

    // Reference model: image words, readback words, flags, and a cycle index
    // into the current shift from which every pin value follows arithmetically.
    logic [DW-1:0] m_img [NW];
    logic [DW-1:0] m_rb  [NW];
    int m_wr, m_rd, m_k, m_h, m_tot;
    bit m_ovf, m_berr, m_done, m_run, m_dc, m_le;
    logic [7:0]  m_hraw;
    logic [31:0] m_rdata;

    always @(posedge fw_clk) begin
        bit en, busy_prev, idle_prev, ex, pu, rd;
        int b;
        en = bus.fw_dev_id_enable;
        if (fw_rst || (en && bus.fw_op_code_w_reset)) begin
            for (int i = 0; i < NW; i++) begin m_img[i] = '0; m_rb[i] = '0; end
            m_wr = 0; m_rd = 0; m_k = 0; m_h = 1; m_tot = 0;
            m_ovf = 0; m_berr = 0; m_done = 0; m_run = 0; m_dc = 0; m_le = 0;
            m_hraw = '0; m_rdata = '0;
        end else begin
            busy_prev = m_run;
            idle_prev = !m_run && !m_dc;
            if (m_dc) begin m_dc = 0; m_done = 1; end
            if (busy_prev) begin
                if (m_k < 2*m_h*L && (m_k % (2*m_h)) == m_h - 1) begin
                    b = m_k / (2*m_h);
                    m_rb[b/DW][b%DW] = bus.fw_config_out;
                end
                m_k++;
                if (m_k == m_tot) begin m_run = 0; m_dc = 1; end
            end
            ex = en && bus.fw_op_code_w_execute;
            pu = en && bus.fw_op_code_w_cfg_array_0 && !ex;
            rd = en && bus.fw_op_code_r_cfg_array_0 && !ex && !pu;
            if (busy_prev && (ex || pu || rd)) m_berr = 1;
            else if (ex) begin
                if (idle_prev) begin
                    m_hraw = bus.sw_write24_0[15:8];
                    m_h    = (m_hraw == 0) ? 1 : int'(m_hraw);
                    m_le   = bus.sw_write24_0[0];
                    m_tot  = 2*m_h*L + (m_le ? 2*m_h : 0);
                    m_k = 0; m_run = 1; m_done = 0; m_rd = 0;
                end
            end else if (pu) begin
                if (m_wr == NW) m_ovf = 1;
                else begin m_img[m_wr] = bus.sw_write24_0[DW-1:0]; m_wr++; end
            end else if (rd) begin
                m_rdata = 32'(m_rb[m_rd]);
                m_rd = (m_rd + 1) % NW;
            end
        end
    end

    always @(negedge fw_clk) if (chk_en) begin
        logic [2:0] e_pins;
        int b;
        e_pins = 3'b000;
        if (m_run) begin
            b = m_k / (2*m_h);
            if (b < L) e_pins = {1'b0, m_img[b/DW][b%DW], 1'((m_k % (2*m_h)) >= m_h)};
            else       e_pins = 3'b100;
        end
        check("pins{load,in,clk}", {29'd0, bus.fw_config_load, bus.fw_config_in, bus.fw_config_clk},
              {29'd0, e_pins});
        check("status", bus.fw_read_status32,
              {16'(m_wr), m_hraw, 4'd0, m_berr, m_ovf, m_done, m_run});
        check("read_data", bus.fw_read_data32, m_rdata);
    end

    task automatic op(bit rs, bit wr, bit rd, bit ex, logic [23:0] d, bit en = 1'b1, bit hr = 1'b0);
        @(posedge fw_clk); #1;
        bus.fw_dev_id_enable         = en;
        bus.fw_op_code_w_reset       = rs;
        bus.fw_op_code_w_cfg_array_0 = wr;
        bus.fw_op_code_r_cfg_array_0 = rd;
        bus.fw_op_code_w_execute     = ex;
        bus.sw_write24_0             = d;
        fw_rst                       = hr;
        @(posedge fw_clk); #1;
        bus.fw_op_code_w_reset       = 1'b0;
        bus.fw_op_code_w_cfg_array_0 = 1'b0;
        bus.fw_op_code_r_cfg_array_0 = 1'b0;
        bus.fw_op_code_w_execute     = 1'b0;
        bus.fw_dev_id_enable         = 1'b1;
        fw_rst                       = 1'b0;
    endtask

    task automatic push(logic [23:0] d); op(0, 1, 0, 0, d); endtask
    task automatic rd_op();              op(0, 0, 1, 0, 24'd0); endtask

    task automatic start(logic [7:0] h, bit le, int gap);
        cap_n = 0; bad_gap = 0; n_busy = 0; n_load = 0; gap_exp = gap;
        op(0, 0, 0, 1, {8'd0, h, 7'd0, le});
    endtask

    task automatic wait_idle(string nm);
        int t = 0;
        while (bus.fw_read_status32[0] !== 1'b0 && t < 4000) begin
            @(posedge fw_clk); #1; t++;
        end
        check({nm, " finished in bound"}, 32'(t < 4000), 32'd1);
        repeat (2) @(posedge fw_clk);
        #1;
    endtask

    initial begin
        logic [23:0] w [4];
        logic [L-1:0] exp_s;
        int t;
        bus.fw_dev_id_enable = 1'b1;
        bus.fw_op_code_w_reset = 1'b0;
        bus.fw_op_code_w_cfg_array_0 = 1'b0;
        bus.fw_op_code_r_cfg_array_0 = 1'b0;
        bus.fw_op_code_w_execute = 1'b0;
        bus.sw_write24_0 = '0;
        repeat (3) @(posedge fw_clk);
        #1 fw_rst = 1'b0;
        chk_en = 1'b1;
        check("reset status", bus.fw_read_status32, 32'd0);
        check("reset read_data", bus.fw_read_data32, 32'd0);
        check("reset pins", {29'd0, bus.fw_config_load, bus.fw_config_in, bus.fw_config_clk}, 32'd0);

        // Directed stream with load pulse
        push(24'h0000A5); push(24'h00003C); push(24'h00000F);
        start(8'd2, 1'b1, 4);
        wait_idle("load run");
        check("stream A5/3C/0F", 32'(cap), 32'h000F3CA5);
        check("clk rises", cap_n, 20);
        check("clk rise spacing errors", bad_gap, 0);
        check("load cycles", n_load, 4);
        check("busy cycles", n_busy, 84);
        check("done flag", 32'(bus.fw_read_status32[1]), 32'd1);
        check("latched H", 32'(bus.fw_read_status32[15:8]), 32'd2);

        // Loopback from an all-ones chain
        chain = '1;
        start(8'd2, 1'b0, 4);
        wait_idle("loopback run");
        rd_op(); check("readback word0", bus.fw_read_data32, 32'h000000FF);
        rd_op(); check("readback word1", bus.fw_read_data32, 32'h000000FF);
        rd_op(); check("readback word2", bus.fw_read_data32, 32'h0000000F);

        // Overflow: fourth push dropped
        op(1, 0, 0, 0, 24'd0);
        check("soft reset status", bus.fw_read_status32, 32'd0);
        for (int i = 0; i < 4; i++) begin w[i] = 24'($urandom); push(w[i]); end
        check("overflow flag", 32'(bus.fw_read_status32[2]), 32'd1);
        check("wr_ptr full", 32'(bus.fw_read_status32[31:16]), 32'd3);
        exp_s = {w[2][3:0], w[1][7:0], w[0][7:0]};
        start(8'd1, 1'b0, 2);
        wait_idle("overflow run");
        check("stream w/o 4th word", 32'(cap), 32'(exp_s));

        // Ops during busy are dropped
        start(8'd3, 1'b0, 6);
        repeat (5) @(posedge fw_clk);
        push(24'hFFFFFF); rd_op(); op(0, 0, 0, 1, 24'h000101);
        wait_idle("busy_err run");
        check("busy_err flag", 32'(bus.fw_read_status32[3]), 32'd1);
        check("stream unchanged", 32'(cap), 32'(exp_s));
        check("clk rise spacing H=3", bad_gap, 0);

        // Abort at bit 7, then a zero image shifts out
        start(8'd2, 1'b0, 4);
        t = 0;
        while (cap_n < 7 && t < 2000) begin @(posedge fw_clk); t++; end
        check("reached bit 7", 32'(t < 2000), 32'd1);
        op(1, 0, 0, 0, 24'd0);
        check("abort status", bus.fw_read_status32, 32'd0);
        check("abort pins", {29'd0, bus.fw_config_load, bus.fw_config_in, bus.fw_config_clk}, 32'd0);
        start(8'd2, 1'b0, 4);
        wait_idle("zero run");
        check("zero stream", 32'(cap), 32'd0);
        check("zero stream rises", cap_n, 20);

        // H=0 runs as H=1
        push(24'h000081); push(24'h000042); push(24'h00000A);
        start(8'd0, 1'b0, 2);
        wait_idle("H0 run");
        check("H0 busy cycles", n_busy, 40);
        check("H0 rise spacing errors", bad_gap, 0);
        check("H0 stream", 32'(cap), 32'h000A4281);

        // Random op mix against the model
        for (int it = 0; it < 400; it++) begin
            bit rs, wr, rdd, ex, en, hr;
            en  = ($urandom_range(0, 9) != 0);
            rs  = ($urandom_range(0, 49) == 0);
            hr  = ($urandom_range(0, 79) == 0);
            wr  = ($urandom_range(0, 9) < 3);
            rdd = ($urandom_range(0, 9) < 3);
            ex  = ($urandom_range(0, 99) < 8);
            chain = L'($urandom);
            op(rs, wr, rdd, ex, {8'($urandom), 6'd0, 2'($urandom_range(0, 3)),
                                 7'($urandom), 1'($urandom)}, en, hr);
            repeat ($urandom_range(0, 3)) @(posedge fw_clk);
        end
        wait_idle("random tail");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
